// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register for the 16-bit MIPS core: DEPTH stages with stall,
// flush, valid tracking, a sticky halt latch and the writeback data mux.
module memwb_pipe_reg #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  memtoreg,
    input  logic                  reg_write,
    input  logic                  halt,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    output logic                  out_valid,
    output logic                  memtoreg_reg,
    output logic                  reg_write_reg,
    output logic                  halt_reg,
    output logic [DATA_W-1:0]     read_data_reg,
    output logic [DATA_W-1:0]     alu_out_reg,
    output logic [REG_ADDR_W-1:0] instr_rd_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  halted
);

    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_chk
        $error("memwb_pipe_reg: DEPTH must be in 1..4");
    end

    typedef struct packed {
        logic                  valid;
        logic                  memtoreg;
        logic                  reg_write;
        logic                  halt;
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_out;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t stage_q [0:DEPTH-1];
    stage_t stage_d [0:DEPTH-1];
    stage_t prev_s  [0:DEPTH-1];
    stage_t in_s;
    logic   halted_q, halted_d;
    logic   retire_halt, hold;

    // Control bits enter pre-qualified so a bubble can never write or halt.
    always_comb begin
        in_s           = '0;
        in_s.valid     = in_valid;
        in_s.memtoreg  = memtoreg & in_valid;
        in_s.reg_write = reg_write & in_valid;
        in_s.halt      = halt & in_valid;
        in_s.read_data = read_data;
        in_s.alu_out   = alu_out;
        in_s.rd        = instr_rd;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_prev
        if (k == 0) begin : g_head
            assign prev_s[k] = in_s;
        end else begin : g_body
            assign prev_s[k] = stage_q[k-1];
        end
    end

    // A retiring HALT freezes the pipe on the very edge it is seen, so it stays visible.
    assign retire_halt = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].halt;
    assign hold        = stall | halted_q | retire_halt;

    always_comb begin
        halted_d = halted_q | (retire_halt & ~flush);
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
            if (flush) begin
                stage_d[k].valid     = 1'b0;
                stage_d[k].memtoreg  = 1'b0;
                stage_d[k].reg_write = 1'b0;
                stage_d[k].halt      = 1'b0;
            end else if (!hold) begin
                stage_d[k] = prev_s[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            halted_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
            halted_q <= halted_d;
        end
    end

    assign out_valid     = stage_q[DEPTH-1].valid;
    assign memtoreg_reg  = stage_q[DEPTH-1].memtoreg;
    assign reg_write_reg = stage_q[DEPTH-1].reg_write & stage_q[DEPTH-1].valid;
    assign halt_reg      = stage_q[DEPTH-1].halt & stage_q[DEPTH-1].valid;
    assign read_data_reg = stage_q[DEPTH-1].read_data;
    assign alu_out_reg   = stage_q[DEPTH-1].alu_out;
    assign instr_rd_reg  = stage_q[DEPTH-1].rd;
    assign wb_data       = memtoreg_reg ? read_data_reg : alu_out_reg;
    assign halted        = halted_q;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Bench for memwb_pipe_reg: DEPTH=1,2,3 instances share stimulus; directed
// scenarios plus randomized traffic checked against a queue-style model.
module tb_memwb_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, memtoreg, reg_write, halt;
    logic [15:0] read_data, alu_out;
    logic [2:0]  instr_rd;

    wire [3:1]       ov, m2r_o, rw_o, h_o, hd_o;
    wire [3:1][15:0] rdd_o, alu_o, wb_o;
    wire [3:1][2:0]  rd_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        memwb_pipe_reg #(.DATA_W(16), .REG_ADDR_W(3), .DEPTH(g)) u_dut (
            .clk(clk), .rst(rst), .stall(stall), .flush(flush),
            .in_valid(in_valid), .memtoreg(memtoreg), .reg_write(reg_write),
            .halt(halt), .read_data(read_data), .alu_out(alu_out),
            .instr_rd(instr_rd), .out_valid(ov[g]), .memtoreg_reg(m2r_o[g]),
            .reg_write_reg(rw_o[g]), .halt_reg(h_o[g]),
            .read_data_reg(rdd_o[g]), .alu_out_reg(alu_o[g]),
            .instr_rd_reg(rd_o[g]), .wb_data(wb_o[g]), .halted(hd_o[g]));
    end

    typedef struct packed {
        logic        v, m, w, h;
        logic [15:0] rdt, alu;
        logic [2:0]  rd;
    } rec_t;

    // Per depth: an ordered list of in-flight instructions, index d-1 is the one at WB.
    rec_t mdl [1:3][0:3];
    logic mh  [1:3];

    task automatic model_update();
        rec_t inrec;
        logic ret;
        inrec = '{in_valid, memtoreg & in_valid, reg_write & in_valid,
                  halt & in_valid, read_data, alu_out, instr_rd};
        for (int d = 1; d <= 3; d++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) mdl[d][k] = '0;
                mh[d] = 1'b0;
            end else if (flush) begin
                for (int k = 0; k < d; k++) begin
                    mdl[d][k].v = 1'b0; mdl[d][k].m = 1'b0;
                    mdl[d][k].w = 1'b0; mdl[d][k].h = 1'b0;
                end
            end else begin
                ret = mdl[d][d-1].v && mdl[d][d-1].h;
                if (!(stall || mh[d] || ret)) begin
                    for (int k = d - 1; k > 0; k--) mdl[d][k] = mdl[d][k-1];
                    mdl[d][0] = inrec;
                end
                if (ret) mh[d] = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; in_valid = 0; memtoreg = 0;
        reg_write = 0; halt = 0; read_data = 0; alu_out = 0; instr_rd = 0;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1; reg_write = 1; halt = 1; alu_out = 16'hFFFF; read_data = 16'hFFFF;
        rst = 1; step(); idle_inputs();
        for (int d = 1; d <= 3; d++) begin
            n_vec++;
            if ({ov[d], m2r_o[d], rw_o[d], h_o[d], hd_o[d], rdd_o[d], alu_o[d], rd_o[d], wb_o[d]} !== 56'h0) begin
                n_err++;
                $display("FAIL reset d=%0d: got ov=%b rw=%b h=%b hd=%b alu=%h wb=%h, want all 0",
                         d, ov[d], rw_o[d], h_o[d], hd_o[d], alu_o[d], wb_o[d]);
            end
        end
    endtask

    task automatic test_basic_d1();
        do_reset();
        in_valid = 1; reg_write = 1; memtoreg = 0; alu_out = 16'h1234; instr_rd = 3;
        step(); idle_inputs();
        n_vec++;
        if ({ov[1], rw_o[1], wb_o[1], rd_o[1]} !== {1'b1, 1'b1, 16'h1234, 3'd3}) begin
            n_err++;
            $display("FAIL basic_d1: got ov=%b rw=%b wb=%h rd=%0d, want 1 1 1234 3",
                     ov[1], rw_o[1], wb_o[1], rd_o[1]);
        end
    endtask

    task automatic test_latency_d3();
        logic [3:0] want_ov;
        want_ov = 4'b0100;
        do_reset();
        in_valid = 1; memtoreg = 1; read_data = 16'hBEEF; alu_out = 16'h0001;
        for (int e = 0; e < 4; e++) begin
            step(); idle_inputs();
            n_vec++;
            if (ov[3] !== want_ov[e] || (want_ov[e] && wb_o[3] !== 16'hBEEF)) begin
                n_err++;
                $display("FAIL latency_d3 edge%0d: got ov=%b wb=%h, want ov=%b wb=BEEF",
                         e, ov[3], wb_o[3], want_ov[e]);
            end
        end
    endtask

    task automatic test_stall_d2();
        do_reset();
        in_valid = 1; reg_write = 1; alu_out = 16'h0B0B; instr_rd = 2; step();
        alu_out = 16'h0A0A; instr_rd = 1; step();
        stall = 1; alu_out = 16'h0C0C; instr_rd = 4;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if ({ov[2], alu_o[2], rd_o[2]} !== {1'b1, 16'h0B0B, 3'd2}) begin
                n_err++;
                $display("FAIL stall_d2 cyc%0d: got ov=%b alu=%h rd=%0d, want 1 0B0B 2",
                         c, ov[2], alu_o[2], rd_o[2]);
            end
        end
        idle_inputs(); step();
        n_vec++;
        if ({ov[2], alu_o[2], rd_o[2]} !== {1'b1, 16'h0A0A, 3'd1}) begin
            n_err++;
            $display("FAIL stall_d2 release: got ov=%b alu=%h rd=%0d, want 1 0A0A 1",
                     ov[2], alu_o[2], rd_o[2]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1; reg_write = 1; alu_out = 16'h0F0F;
        for (int c = 0; c < 3; c++) step();
        flush = 1; stall = 1; step();
        for (int d = 1; d <= 3; d++) begin
            n_vec++;
            if ({ov[d], rw_o[d], h_o[d]} !== 3'b000) begin
                n_err++;
                $display("FAIL flush d=%0d: got ov=%b rw=%b h=%b, want 0 0 0", d, ov[d], rw_o[d], h_o[d]);
            end
        end
        idle_inputs(); in_valid = 1; reg_write = 1; alu_out = 16'h0077; step();
        n_vec++;
        if ({ov[1], rw_o[1], alu_o[1]} !== {2'b11, 16'h0077}) begin
            n_err++;
            $display("FAIL flush_refill_d1: got ov=%b rw=%b alu=%h, want 1 1 0077", ov[1], rw_o[1], alu_o[1]);
        end
        in_valid = 0; reg_write = 0; step(); step();
        n_vec++;
        if ({ov[3], rw_o[3], alu_o[3]} !== {2'b11, 16'h0077}) begin
            n_err++;
            $display("FAIL flush_refill_d3: got ov=%b rw=%b alu=%h, want 1 1 0077", ov[3], rw_o[3], alu_o[3]);
        end
    endtask

    task automatic test_halt_d1();
        do_reset();
        in_valid = 1; halt = 1; alu_out = 16'h0A0A; step();
        n_vec++;
        if ({h_o[1], hd_o[1]} !== 2'b10) begin
            n_err++;
            $display("FAIL halt_enter: got halt_reg=%b halted=%b, want 1 0", h_o[1], hd_o[1]);
        end
        halt = 0; reg_write = 1; alu_out = 16'h5555;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if ({h_o[1], hd_o[1], ov[1], rw_o[1], alu_o[1]} !== {4'b1110, 16'h0A0A}) begin
                n_err++;
                $display("FAIL halt_frozen cyc%0d: got h=%b hd=%b ov=%b rw=%b alu=%h, want 1 1 1 0 0A0A",
                         c, h_o[1], hd_o[1], ov[1], rw_o[1], alu_o[1]);
            end
        end
        rst = 1; step(); idle_inputs();
        n_vec++;
        if ({ov[1], rw_o[1], h_o[1], hd_o[1], wb_o[1]} !== 20'h0) begin
            n_err++;
            $display("FAIL halt_reset: got ov=%b rw=%b h=%b hd=%b wb=%h, want all 0",
                     ov[1], rw_o[1], h_o[1], hd_o[1], wb_o[1]);
        end
    endtask

    task automatic test_invalid_ctrl();
        do_reset();
        in_valid = 0; reg_write = 1; halt = 1; memtoreg = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if ({ov[1], rw_o[1], h_o[1], hd_o[1], m2r_o[1]} !== 5'b0) begin
                n_err++;
                $display("FAIL invalid_ctrl cyc%0d: got ov=%b rw=%b h=%b hd=%b m2r=%b, want all 0",
                         c, ov[1], rw_o[1], h_o[1], hd_o[1], m2r_o[1]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        rec_t e;
        logic [55:0] got, exp;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(99) < 2);
            flush     = ($urandom_range(99) < 5);
            stall     = ($urandom_range(99) < 15);
            in_valid  = ($urandom_range(99) < 70);
            memtoreg  = $urandom_range(1);
            reg_write = $urandom_range(1);
            halt      = ($urandom_range(99) < 4);
            read_data = 16'($urandom);
            alu_out   = 16'($urandom);
            instr_rd  = 3'($urandom);
            step();
            for (int d = 1; d <= 3; d++) begin
                e   = mdl[d][d-1];
                exp = {e.v, e.m, e.w & e.v, e.h & e.v, mh[d], e.rdt, e.alu, e.rd,
                       (e.m ? e.rdt : e.alu)};
                got = {ov[d], m2r_o[d], rw_o[d], h_o[d], hd_o[d], rdd_o[d], alu_o[d],
                       rd_o[d], wb_o[d]};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random cyc%0d d=%0d: got %h, want %h", c, d, got, exp);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        for (int d = 1; d <= 3; d++) begin
            for (int k = 0; k < 4; k++) mdl[d][k] = '0;
            mh[d] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic_d1();
        test_latency_d3();
        test_stall_d2();
        test_flush();
        test_halt_d1();
        test_invalid_ctrl();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
